// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: fetch at CurrentPC, hold for decode, advance on retire.
// Optional PC_ALIGN_CHECK_EN adds a sticky misaligned-PC fault (FaultMisalign port, FAULT state).
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          INSTR_W  = 32,
    parameter int          CNT_W    = 32
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [63:0]        NextPC,
    input  logic               InstrRetire,
    output logic               IMemReq,
    output logic [63:0]        IMemAddr,
    input  logic               IMemAck,
    input  logic [INSTR_W-1:0] IMemData,
    output logic [63:0]        CurrentPC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic [CNT_W-1:0]   RetireCount
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic               FaultMisalign
`endif
);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
`endif

    state_t state, state_nxt;
    logic   take_ack;
    logic   take_retire;
    logic   go_fault;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Ack and retire are qualified by state here, so stray strobes never reach the datapath.
    always_comb begin
        state_nxt   = state;
        IMemReq     = 1'b0;
        take_ack    = 1'b0;
        take_retire = 1'b0;
        go_fault    = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                IMemReq = 1'b1;
                if (IMemAck) begin
                    take_ack  = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (InstrRetire) begin
                    take_retire = 1'b1;
                    state_nxt   = S_FETCH;
`ifdef PC_ALIGN_CHECK_EN
                    if (NextPC[1:0] != 2'b00) begin
                        go_fault  = 1'b1;
                        state_nxt = S_FAULT;
                    end
`endif
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            S_FAULT: state_nxt = S_FAULT;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            CurrentPC   <= RESET_PC;
            Instruction <= '0;
            InstrValid  <= 1'b0;
            RetireCount <= '0;
        end else begin
            if (take_ack) begin
                Instruction <= IMemData;
                InstrValid  <= 1'b1;
            end
            if (take_retire) begin
                CurrentPC   <= NextPC;
                RetireCount <= RetireCount + CNT_W'(1);
                InstrValid  <= 1'b0;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L)      FaultMisalign <= 1'b0;
        else if (go_fault) FaultMisalign <= 1'b1;
    end
`else
    logic unused_fault;
    assign unused_fault = go_fault;
`endif

    // Low address bits are forced to zero so a misaligned PC still fetches its containing word.
    assign IMemAddr = {CurrentPC[63:2], 2'b00};

endmodule
